// File: rtl/idft4point_seq.sv
// Sequential 4-point inverse DFT. Latches one complex spectrum on start, then
// writes one time-domain sample per cycle (n = 0..3) and pulses done.
// The twiddles are +/-1 and +/-j, so each sample is a signed add/subtract of
// the latched bins.
module idft4point_seq #(
    parameter int WIDTH    = 16,
    parameter bit SCALE_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] Xr0,
    input  logic signed [WIDTH-1:0] Xr1,
    input  logic signed [WIDTH-1:0] Xr2,
    input  logic signed [WIDTH-1:0] Xr3,
    input  logic signed [WIDTH-1:0] Xi0,
    input  logic signed [WIDTH-1:0] Xi1,
    input  logic signed [WIDTH-1:0] Xi2,
    input  logic signed [WIDTH-1:0] Xi3,
    output logic signed [WIDTH-1:0] xr0,
    output logic signed [WIDTH-1:0] xr1,
    output logic signed [WIDTH-1:0] xr2,
    output logic signed [WIDTH-1:0] xr3,
    output logic signed [WIDTH-1:0] xi0,
    output logic signed [WIDTH-1:0] xi1,
    output logic signed [WIDTH-1:0] xi2,
    output logic signed [WIDTH-1:0] xi3,
    output logic                    busy,
    output logic                    done
);

    // Four operands of WIDTH bits need two guard bits to sum without overflow.
    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              n_q, n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic signed [WIDTH-1:0] lr_q [4];
    logic signed [WIDTH-1:0] lr_d [4];
    logic signed [WIDTH-1:0] li_q [4];
    logic signed [WIDTH-1:0] li_d [4];
    logic signed [WIDTH-1:0] xr_q [4];
    logic signed [WIDTH-1:0] xr_d [4];
    logic signed [WIDTH-1:0] xi_q [4];
    logic signed [WIDTH-1:0] xi_d [4];

    logic signed [SW-1:0] a0, a1, a2, a3;
    logic signed [SW-1:0] b0, b1, b2, b3;
    logic signed [SW-1:0] re_sum, im_sum;

    function automatic logic signed [SW-1:0] sx(input logic signed [WIDTH-1:0] v);
        return {{2{v[WIDTH-1]}}, v};
    endfunction

    // Scaled mode: arithmetic shift floors toward -inf and always fits WIDTH.
    // Unscaled mode: clamp the wide sum into the WIDTH range.
    function automatic logic signed [WIDTH-1:0] fit(input logic signed [SW-1:0] s);
        if (SCALE_EN) begin
            return WIDTH'(s >>> 2);
        end else if (s > MAXV) begin
            return WIDTH'(MAXV);
        end else if (s < MINV) begin
            return WIDTH'(MINV);
        end else begin
            return WIDTH'(s);
        end
    endfunction

    // Sign-extended latched bins and the butterfly sums for the current sample n.
    always_comb begin
        a0 = sx(lr_q[0]);
        a1 = sx(lr_q[1]);
        a2 = sx(lr_q[2]);
        a3 = sx(lr_q[3]);
        b0 = sx(li_q[0]);
        b1 = sx(li_q[1]);
        b2 = sx(li_q[2]);
        b3 = sx(li_q[3]);
        case (n_q)
            2'd0: begin
                re_sum = a0 + a1 + a2 + a3;
                im_sum = b0 + b1 + b2 + b3;
            end
            2'd1: begin
                re_sum = a0 - b1 - a2 + b3;
                im_sum = b0 + a1 - b2 - a3;
            end
            2'd2: begin
                re_sum = a0 - a1 + a2 - a3;
                im_sum = b0 - b1 + b2 - b3;
            end
            default: begin
                re_sum = a0 + b1 - a2 - b3;
                im_sum = b0 - a1 - b2 + a3;
            end
        endcase
    end

    // Next-state logic: IDLE latches the frame, CALC writes sample n, FIN pulses done.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lr_d    = lr_q;
        li_d    = li_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lr_d[0] = Xr0;
                    lr_d[1] = Xr1;
                    lr_d[2] = Xr2;
                    lr_d[3] = Xr3;
                    li_d[0] = Xi0;
                    li_d[1] = Xi1;
                    li_d[2] = Xi2;
                    li_d[3] = Xi3;
                    busy_d  = 1'b1;
                    n_d     = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                xr_d[n_q] = fit(re_sum);
                xi_d[n_q] = fit(im_sum);
                n_d       = n_q + 2'd1;
                if (n_q == 2'd3) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous clear of FSM, latches and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                lr_q[i] <= '0;
                li_q[i] <= '0;
                xr_q[i] <= '0;
                xi_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lr_q    <= lr_d;
            li_q    <= li_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
        end
    end

    assign xr0  = xr_q[0];
    assign xr1  = xr_q[1];
    assign xr2  = xr_q[2];
    assign xr3  = xr_q[3];
    assign xi0  = xi_q[0];
    assign xi1  = xi_q[1];
    assign xi2  = xi_q[2];
    assign xi3  = xi_q[3];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_idft4point_seq.sv
// Directed bench for idft4point_seq: one scaled instance and one unscaled
// instance share the same stimulus.
module tb_idft4point_seq;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic signed [15:0] Xr0, Xr1, Xr2, Xr3, Xi0, Xi1, Xi2, Xi3;
    logic signed [15:0] sr0, sr1, sr2, sr3, si0, si1, si2, si3;
    logic signed [15:0] ur0, ur1, ur2, ur3, ui0, ui1, ui2, ui3;
    logic s_busy, s_done, u_busy, u_done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    idft4point_seq #(.WIDTH(16), .SCALE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .Xr0(Xr0), .Xr1(Xr1), .Xr2(Xr2), .Xr3(Xr3),
        .Xi0(Xi0), .Xi1(Xi1), .Xi2(Xi2), .Xi3(Xi3),
        .xr0(sr0), .xr1(sr1), .xr2(sr2), .xr3(sr3),
        .xi0(si0), .xi1(si1), .xi2(si2), .xi3(si3),
        .busy(s_busy), .done(s_done)
    );

    idft4point_seq #(.WIDTH(16), .SCALE_EN(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .start(start),
        .Xr0(Xr0), .Xr1(Xr1), .Xr2(Xr2), .Xr3(Xr3),
        .Xi0(Xi0), .Xi1(Xi1), .Xi2(Xi2), .Xi3(Xi3),
        .xr0(ur0), .xr1(ur1), .xr2(ur2), .xr3(ur3),
        .xi0(ui0), .xi1(ui1), .xi2(ui2), .xi3(ui3),
        .busy(u_busy), .done(u_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input int r0, input int r1, input int r2, input int r3,
                         input int i0, input int i1, input int i2, input int i3);
        chk({tag, ".xr0"}, sr0, r0);
        chk({tag, ".xr1"}, sr1, r1);
        chk({tag, ".xr2"}, sr2, r2);
        chk({tag, ".xr3"}, sr3, r3);
        chk({tag, ".xi0"}, si0, i0);
        chk({tag, ".xi1"}, si1, i1);
        chk({tag, ".xi2"}, si2, i2);
        chk({tag, ".xi3"}, si3, i3);
    endtask

    task automatic chk_u(input string tag, input int r0, input int r1, input int r2, input int r3,
                         input int i0, input int i1, input int i2, input int i3);
        chk({tag, ".uxr0"}, ur0, r0);
        chk({tag, ".uxr1"}, ur1, r1);
        chk({tag, ".uxr2"}, ur2, r2);
        chk({tag, ".uxr3"}, ur3, r3);
        chk({tag, ".uxi0"}, ui0, i0);
        chk({tag, ".uxi1"}, ui1, i1);
        chk({tag, ".uxi2"}, ui2, i2);
        chk({tag, ".uxi3"}, ui3, i3);
    endtask

    task automatic set_in(input int r0, input int r1, input int r2, input int r3,
                          input int i0, input int i1, input int i2, input int i3);
        Xr0 = 16'(r0); Xr1 = 16'(r1); Xr2 = 16'(r2); Xr3 = 16'(r3);
        Xi0 = 16'(i0); Xi1 = 16'(i1); Xi2 = 16'(i2); Xi3 = 16'(i3);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse; checks busy/done timing through E+6.
    task automatic frame(input string tag);
        @(negedge clk);
        start = 1'b1;
        tick();                               // edge E
        start = 1'b0;
        chk({tag, ".busyE"}, s_busy, 1);
        chk({tag, ".doneE"}, s_done, 0);
        repeat (4) tick();                    // E+4
        chk({tag, ".done4"}, s_done, 0);
        chk({tag, ".busy4"}, s_busy, 1);
        tick();                               // E+5
        chk({tag, ".done5"}, s_done, 1);
        chk({tag, ".busy5"}, s_busy, 0);
        chk({tag, ".udone5"}, u_done, 1);
        tick();                               // E+6
        chk({tag, ".done6"}, s_done, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst.busy", s_busy, 0);
        chk("rst.done", s_done, 0);
        chk_s("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // DC bin
        set_in(4000, 0, 0, 0, 0, 0, 0, 0);
        frame("dc");
        chk_s("dc", 1000, 1000, 1000, 1000, 0, 0, 0, 0);
        chk_u("dc", 4000, 4000, 4000, 4000, 0, 0, 0, 0);

        // Bin 1
        set_in(0, 4000, 0, 0, 0, 0, 0, 0);
        frame("b1");
        chk_s("b1", 1000, 0, -1000, 0, 0, 1000, 0, -1000);

        // Floor rounding
        set_in(-1, 0, 0, 0, 0, 0, 0, 0);
        frame("fneg");
        chk_s("fneg", -1, -1, -1, -1, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        frame("fpos");
        chk_s("fpos", 0, 0, 0, 0, 0, 0, 0, 0);

        // Saturation in the unscaled instance
        set_in(16000, 16000, 16000, 16000, 0, 0, 0, 0);
        frame("satp");
        chk_u("satp", 32767, 0, 0, 0, 0, 0, 0, 0);
        chk_s("satp", 16000, 0, 0, 0, 0, 0, 0, 0);
        set_in(-16000, -16000, -16000, -16000, 0, 0, 0, 0);
        frame("satn");
        chk_u("satn", -32768, 0, 0, 0, 0, 0, 0, 0);
        chk_s("satn", -16000, 0, 0, 0, 0, 0, 0, 0);

        // Start pulsed at E+2 with other inputs is ignored
        set_in(0, 0, 0, 0, 400, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        tick();                               // E
        start = 1'b0;
        tick();                               // E+1
        set_in(800, 0, 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();                               // E+2
        start = 1'b0;
        tick();
        tick();                               // E+4
        tick();                               // E+5
        chk("ign.done5", s_done, 1);
        chk_s("ign", 0, 0, 0, 0, 100, 100, 100, 100);
        chk_u("ign", 0, 0, 0, 0, 400, 400, 400, 400);
        tick();
        tick();
        chk("ign.noframe", s_busy, 0);

        // Start held high: frames every 6 cycles; inputs changed mid-frame
        // only take effect at the next acceptance.
        set_in(4000, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        tick();                               // E
        set_in(-4000, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();                    // E+4
        chk("hold.done4", s_done, 0);
        tick();                               // E+5
        chk("hold.done5", s_done, 1);
        chk_s("hold1", 1000, 1000, 1000, 1000, 0, 0, 0, 0);
        tick();                               // E+6
        chk("hold.done6", s_done, 0);
        chk("hold.busy6", s_busy, 1);
        repeat (4) tick();                    // E+10
        chk("hold.done10", s_done, 0);
        tick();                               // E+11
        chk("hold.done11", s_done, 1);
        chk_s("hold2", -1000, -1000, -1000, -1000, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (8) tick();
        chk("hold.idle", s_busy, 0);

        // Mid-frame view, then reset aborts the frame
        set_in(4000, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        tick();                               // E
        start = 1'b0;
        tick();
        tick();                               // E+2
        chk("mid.xr0", sr0, 1000);
        chk("mid.xr1", sr1, 1000);
        chk("mid.xr2", sr2, -1000);
        reset = 1'b1;
        #1;
        chk("abort.busy", s_busy, 0);
        chk_s("abort", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen_done = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (s_done) seen_done = 1;
            end
            chk("abort.nodone", seen_done, 0);
        end

        // Normal frame after the abort
        set_in(0, 4000, 0, 0, 0, 0, 0, 0);
        frame("post");
        chk_s("post", 1000, 0, -1000, 0, 0, 1000, 0, -1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
